pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32I pipeline (F, D, E, M, W).
- Drives the fetch stage's stallF/stallD and the downstream stall/flush strobes.
- Resolves three hazards: load-use bubbles, taken-branch redirect flushes, and multi-cycle data-memory waits with a timeout watchdog.
- Sits beside the datapath; takes register indices and status from the D/E/M stages.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_perf_cnt.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encodings,
// register-index constants and a small operand-match helper.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;
  localparam int PERF_W = 32;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_REDIRECT   = 2'b10,
    ST_MEM_WAIT   = 2'b11
  } hz_state_e;

  // True when the D instruction actually reads a source that equals rd.
  function automatic logic src_match(input logic                 use_src,
                                     input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: free-running 32-bit event counters for the hazard sequencer.
// Only instantiated when HAZARD_PERF_EN is defined.
module hazard_perf_cnt
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_cyc_inc,
  input  logic              flush_inc,
  input  logic              loaduse_inc,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt,
  output logic [PERF_W-1:0] perf_loaduse_cnt
);

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cyc   <= '0;
      perf_flush_cnt   <= '0;
      perf_loaduse_cnt <= '0;
    end else begin
      if (stall_cyc_inc) perf_stall_cyc   <= perf_stall_cyc + PERF_W'(1);
      if (flush_inc)     perf_flush_cnt   <= perf_flush_cnt + PERF_W'(1);
      if (loaduse_inc)   perf_loaduse_cnt <= perf_loaduse_cnt + PERF_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles,
// branch redirect flushes and data-memory waits with a sticky timeout flag.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_valid,
  input  logic [REG_IDX_W-1:0] d_rs1,
  input  logic [REG_IDX_W-1:0] d_rs2,
  input  logic                 d_use_rs1,
  input  logic                 d_use_rs2,
  input  logic                 e_valid,
  input  logic [REG_IDX_W-1:0] e_rd,
  input  logic                 e_is_load,
  input  logic                 branch_sig,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 stallE,
  output logic                 stallM,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 mem_err,
  output logic [1:0]           state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]    perf_stall_cyc,
  output logic [PERF_W-1:0]    perf_flush_cnt,
  output logic [PERF_W-1:0]    perf_loaduse_cnt
`endif
);

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_d;
  logic            memwait, loaduse_raw, loaduse_ok, loaduse;

  assign memwait     = mem_req && !mem_ack;
  assign loaduse_raw = d_valid && e_valid && e_is_load && (e_rd != X0_IDX) &&
                       (src_match(d_use_rs1, d_rs1, e_rd) ||
                        src_match(d_use_rs2, d_rs2, e_rd));
  // The cycle after a bubble or a redirect, D/E no longer hold the hazard pair.
  assign loaduse_ok  = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
  assign loaduse     = loaduse_raw && loaduse_ok;

  // NOTE: every output and next-state term gets a default first so this block
  // can never infer a latch, whatever branch the priority chain takes.
  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    state_d    = ST_RUN;
    wait_cnt_d = '0;

    // Reset gates the strobes so they drop the instant reset rises.
    if (!reset) begin
      if (memwait) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end else if (branch_sig) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (loaduse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end

    if (memwait) begin
      state_d = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT)       wait_cnt_d = TO_W'(1);
      else if (wait_cnt_q < TIMEOUT_VAL) wait_cnt_d = wait_cnt_q + TO_W'(1);
      else                               wait_cnt_d = wait_cnt_q;
    end else if (branch_sig &&
                 (state_q == ST_RUN || state_q == ST_LOAD_STALL)) begin
      state_d = ST_REDIRECT;
    end else if (loaduse && state_q == ST_RUN) begin
      state_d = ST_LOAD_STALL;
    end
  end

  assign mem_err_d = mem_err || (memwait && (wait_cnt_d == TIMEOUT_VAL));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err    <= mem_err_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf (
    .clk              (clk),
    .reset            (reset),
    .stall_cyc_inc    (stallF),
    .flush_inc        (flushD),
    .loaduse_inc      (stallD && flushE),
    .perf_stall_cyc   (perf_stall_cyc),
    .perf_flush_cnt   (perf_flush_cnt),
    .perf_loaduse_cnt (perf_loaduse_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;

  // Model's memory of what the previous cycle did (values match state_o codes).
  localparam int P_NONE = 0, P_BUBBLE = 1, P_REDIRECT = 2, P_WAIT = 3;
  localparam int A_NONE = 0, A_WAIT = 1, A_FLUSH = 2, A_BUBBLE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_valid = 1'b0, d_use_rs1 = 1'b0, d_use_rs2 = 1'b0;
  logic [4:0] d_rs1 = '0, d_rs2 = '0, e_rd = '0;
  logic       e_valid = 1'b0, e_is_load = 1'b0;
  logic       branch_sig = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, mem_err;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_loaduse_cnt;
  int unsigned m_stall_cyc = 0, m_flush_cnt = 0, m_loaduse_cnt = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int m_prev = P_NONE;
  int m_wait = 0;
  bit m_err  = 1'b0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs1      (d_rs1),
    .d_rs2      (d_rs2),
    .d_use_rs1  (d_use_rs1),
    .d_use_rs2  (d_use_rs2),
    .e_valid    (e_valid),
    .e_rd       (e_rd),
    .e_is_load  (e_is_load),
    .branch_sig (branch_sig),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .stallM     (stallM),
    .flushD     (flushD),
    .flushE     (flushE),
    .mem_err    (mem_err),
    .state_o    (state_o)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cyc   (perf_stall_cyc),
    .perf_flush_cnt   (perf_flush_cnt),
    .perf_loaduse_cnt (perf_loaduse_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the controller must do this cycle, from the hazard rules alone.
  function automatic int calc_action(input int prev);
    bit lu;
    lu = d_valid && e_valid && e_is_load && (e_rd != 0) &&
         ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
    if (mem_req && !mem_ack)                          return A_WAIT;
    if (branch_sig)                                   return A_FLUSH;
    if (lu && prev != P_BUBBLE && prev != P_REDIRECT) return A_BUBBLE;
    return A_NONE;
  endfunction

  // Reference model: advance on each clock, clear on reset.
  always @(posedge clk or posedge reset) begin
    int a;
    if (reset) begin
      m_prev = P_NONE;
      m_wait = 0;
      m_err  = 1'b0;
`ifdef HAZARD_PERF_EN
      m_stall_cyc = 0; m_flush_cnt = 0; m_loaduse_cnt = 0;
`endif
    end else begin
      a = calc_action(m_prev);
`ifdef HAZARD_PERF_EN
      if (a == A_WAIT || a == A_BUBBLE) m_stall_cyc++;
      if (a == A_FLUSH)  m_flush_cnt++;
      if (a == A_BUBBLE) m_loaduse_cnt++;
`endif
      case (a)
        A_WAIT: begin
          if (m_prev != P_WAIT) m_wait = 1;
          else if (m_wait < TIMEOUT) m_wait = m_wait + 1;
          if (m_wait == TIMEOUT) m_err = 1'b1;
          m_prev = P_WAIT;
        end
        A_FLUSH: begin
          m_wait = 0;
          m_prev = (m_prev == P_NONE || m_prev == P_BUBBLE) ? P_REDIRECT : P_NONE;
        end
        A_BUBBLE: begin
          m_wait = 0;
          m_prev = (m_prev == P_NONE) ? P_BUBBLE : P_NONE;
        end
        default: begin
          m_wait = 0;
          m_prev = P_NONE;
        end
      endcase
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    logic [5:0] es;
    int a;
    a  = calc_action(m_prev);
    es = '0;
    if (!reset) begin
      case (a)
        A_WAIT:   es = 6'b111100;
        A_FLUSH:  es = 6'b000011;
        A_BUBBLE: es = 6'b110001;
        default:  es = 6'b000000;
      endcase
    end
    check("model_cycle",
          {23'd0, stallF, stallD, stallE, stallM, flushD, flushE, mem_err, state_o},
          {23'd0, es, m_err, 2'(m_prev)});
  end

  function automatic logic [31:0] strobes();
    return {26'd0, stallF, stallD, stallE, stallM, flushD, flushE};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_use_rs1 = 0; d_use_rs2 = 0; d_rs1 = 0; d_rs2 = 0;
    e_valid = 0; e_is_load = 0; e_rd = 0;
    branch_sig = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1);
    e_valid = 1; e_is_load = 1; e_rd = rd;
    d_valid = 1; d_use_rs1 = 1; d_rs1 = rs1; d_use_rs2 = 0; d_rs2 = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", state_o, 0);
    check("rst_strobes", strobes(), 0);
    check("rst_err", mem_err, 0);
    step(); reset = 0;
    @(negedge clk);
    check("idle_strobes", strobes(), 0);

    // Load-use: one bubble, then LOAD_STALL suppresses the still-matching pair.
    step(); set_lu(5, 5);
    @(negedge clk);
    check("lu_strobes", strobes(), 6'b110001);
    check("lu_state", state_o, 0);
    step();
    @(negedge clk);
    check("lu_after_strobes", strobes(), 0);
    check("lu_after_state", state_o, 1);
    step(); idle();
    @(negedge clk);
    check("lu_back_state", state_o, 0);

    // Load into x0 never stalls.
    step(); set_lu(0, 0);
    @(negedge clk);
    check("x0_strobes", strobes(), 0);

    // Branch wins over load-use; REDIRECT suppresses the match next cycle.
    step(); set_lu(5, 5); branch_sig = 1;
    @(negedge clk);
    check("br_lu_strobes", strobes(), 6'b000011);
    step(); branch_sig = 0;
    @(negedge clk);
    check("br_after_state", state_o, 2);
    check("br_after_strobes", strobes(), 0);
    step(); idle();
    @(negedge clk);
    check("br_back_state", state_o, 0);

    // Memory wait 3 cycles with a pending branch, ack on the 4th.
    step(); mem_req = 1; branch_sig = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_stalls", strobes(), 6'b111100);
      step();
    end
    mem_ack = 1;
    @(negedge clk);
    check("mw_ack_strobes", strobes(), 6'b000011);
    check("mw_ack_state", state_o, 3);
    step(); idle();
    @(negedge clk);
    check("mw_back_state", state_o, 0);
    check("mw_no_err", mem_err, 0);

    // Timeout: err rises once four wait cycles have elapsed and sticks.
    step(); mem_req = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("to_err", mem_err, (i >= 5) ? 1 : 0);
      check("to_stalls", strobes(), 6'b111100);
      step();
    end
    mem_ack = 1;
    @(negedge clk);
    check("to_ack_strobes", strobes(), 0);
    check("to_ack_err", mem_err, 1);
    step(); idle();
    @(negedge clk);
    check("to_sticky_err", mem_err, 1);

    // Async reset between edges while a wait is in progress.
    step(); mem_req = 1;
    step();
    @(negedge clk);
    check("ar_pre_state", state_o, 3);
    step();
    #2 reset = 1;
    #1;
    check("ar_strobes", strobes(), 0);
    check("ar_state", state_o, 0);
    check("ar_err", mem_err, 0);
    step(); reset = 0; idle();

    // Randomized traffic; mem_req holds until acknowledged.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (reset) reset = 0;
      else if ($urandom_range(0, 399) == 0) reset = 1;
      d_valid    = 1'($urandom);
      d_use_rs1  = 1'($urandom);
      d_use_rs2  = 1'($urandom);
      d_rs1      = 5'($urandom_range(0, 3));
      d_rs2      = 5'($urandom_range(0, 3));
      e_valid    = ($urandom_range(0, 3) != 0);
      e_is_load  = 1'($urandom);
      e_rd       = 5'($urandom_range(0, 3));
      branch_sig = ($urandom_range(0, 5) == 0);
      if (mem_ack) begin
        mem_req = 0;
        mem_ack = 0;
      end
      if (!mem_req) mem_req = ($urandom_range(0, 7) == 0);
      mem_ack = mem_req && ($urandom_range(0, 3) == 0);
    end
    step(); idle();
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    check("perf_stall", perf_stall_cyc, m_stall_cyc);
    check("perf_flush", perf_flush_cnt, m_flush_cnt);
    check("perf_loaduse", perf_loaduse_cnt, m_loaduse_cnt);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
